float_to_int: RTL and testbench

- Sequential converter from an IEEE754 single-precision value to an 8-bit unsigned integer. It is the inverse path of the grayscale pipeline's int-to-float stage.
- Converts float-domain luminance results back to 8-bit pixel values, with rounding and saturation.
- Valid/ready handshake on both sides.
- Iterative alignment shifter: one bit per cycle after a fixed 16-bit pre-shift.

---
 rtl/float_pkg.sv | 41 ++++
 rtl/float_to_int_if.sv | 23 ++
 rtl/fp32_unpack.sv | 48 ++++
 rtl/float_to_int.sv | 146 ++++++++++++++
 tb/tb_float_to_int.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/float_pkg.sv
// Shared FP32 field layout, conversion constants, flag indices and FSM states
// for the float-to-uint8 return path of the grayscale pipeline.
package float_pkg;

  localparam int unsigned FP_W   = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned K_W    = 4;

  localparam int unsigned SIGN_POS = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MAN_MSB  = 22;

  localparam int unsigned BIAS        = 127;
  localparam int unsigned E_MIN_ROUND = BIAS - 1;       // 0.5 <= |x|: may round up to 1
  localparam int unsigned E_SAT       = BIAS + OUT_W;   // |x| >= 256
  localparam int unsigned E_ALIGN0    = E_SAT - 1;      // exponent needing no alignment
  localparam int unsigned PRESHIFT    = SIG_W - OUT_W;

  localparam int unsigned FLAG_SAT = 0;
  localparam int unsigned FLAG_NEG = 1;
  localparam int unsigned FLAG_NAN = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/float_to_int_if.sv
// Valid/ready request and response channels of the float-to-int converter.
interface float_to_int_if;
  import float_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [FP_W-1:0]   float_input;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  int_output;
  logic [FLAG_W-1:0] out_flags;

  modport master (
    output in_valid, float_input, out_ready,
    input  in_ready, out_valid, int_output, out_flags
  );

  modport slave (
    input  in_valid, float_input, out_ready,
    output in_ready, out_valid, int_output, out_flags
  );

endinterface

// File: rtl/fp32_unpack.sv
// Combinational FP32 field split and classification; also prepares the
// pre-shifted quotient, guard and sticky bits plus the alignment count.
module fp32_unpack
  import float_pkg::*;
(
  input  logic [FP_W-1:0]  fp_i,
  output logic             nan_c_o,
  output logic             neg_c_o,
  output logic             sat_c_o,
  output logic             zero_c_o,
  output logic [K_W-1:0]   k_c_o,
  output logic [OUT_W-1:0] q_c_o,
  output logic             g_c_o,
  output logic             s_c_o
);

  fp32_t            f;
  logic [SIG_W-1:0] sig;
  logic             nonzero;

  assign f       = fp32_t'(fp_i);
  assign sig     = {1'b1, f.man};
  assign nonzero = (f.exp != '0) || (f.man != '0);

  // Priority classification: NaN, negative, saturate, underflow-to-zero.
  always_comb begin
    nan_c_o  = 1'b0;
    neg_c_o  = 1'b0;
    sat_c_o  = 1'b0;
    zero_c_o = 1'b0;
    if ((f.exp == '1) && (f.man != '0)) begin
      nan_c_o = 1'b1;
    end else if (f.sign && nonzero) begin
      neg_c_o = 1'b1;
    end else if (f.exp >= EXP_W'(E_SAT)) begin
      sat_c_o = 1'b1;
    end else if (f.exp < EXP_W'(E_MIN_ROUND)) begin
      zero_c_o = 1'b1;
    end
  end

  // Only meaningful for exponents in the rounding window (count 0..8).
  assign k_c_o = K_W'(EXP_W'(E_ALIGN0) - f.exp);
  assign q_c_o = sig[SIG_W-1 -: OUT_W];
  assign g_c_o = sig[PRESHIFT-1];
  assign s_c_o = |sig[PRESHIFT-2:0];

endmodule

// File: rtl/float_to_int.sv
// Iterative FP32 to uint8 converter: classify on accept, shift right one bit
// per cycle, round (RNE or truncate) with saturation, then hold the result.
module float_to_int
  import float_pkg::*;
#(
  parameter int unsigned ROUND_MODE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  float_to_int_if.slave  bus
);

  localparam logic RNE = (ROUND_MODE == 0);

  state_e            state_q, state_d;
  logic [OUT_W-1:0]  q_q, q_d;
  logic              g_q, g_d;
  logic              s_q, s_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [OUT_W-1:0]  res_q, res_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic              nan_c, neg_c, sat_c, zero_c;
  logic [K_W-1:0]    k_c;
  logic [OUT_W-1:0]  q_c;
  logic              g_c, s_c;
  logic              round_inc_c;
  logic [OUT_W:0]    round_sum_c;

  fp32_unpack u_unpack (
    .fp_i     (bus.float_input),
    .nan_c_o  (nan_c),
    .neg_c_o  (neg_c),
    .sat_c_o  (sat_c),
    .zero_c_o (zero_c),
    .k_c_o    (k_c),
    .q_c_o    (q_c),
    .g_c_o    (g_c),
    .s_c_o    (s_c)
  );

  // Round-half-to-even increment; truncation mode never increments.
  assign round_inc_c = RNE & g_q & (s_q | q_q[0]);
  assign round_sum_c = {1'b0, q_q} + (OUT_W+1)'(round_inc_c);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    g_d     = g_q;
    s_d     = s_q;
    k_d     = k_q;
    res_d   = res_q;
    flags_d = flags_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_OUT;
          flags_d = '0;
          if (nan_c) begin
            res_d             = '0;
            flags_d[FLAG_NAN] = 1'b1;
          end else if (neg_c) begin
            res_d             = '0;
            flags_d[FLAG_NEG] = 1'b1;
          end else if (sat_c) begin
            res_d             = '1;
            flags_d[FLAG_SAT] = 1'b1;
          end else if (zero_c) begin
            res_d = '0;
          end else begin
            q_d     = q_c;
            g_d     = g_c;
            s_d     = s_c;
            k_d     = k_c;
            state_d = (k_c == '0) ? ST_ROUND : ST_ALIGN;
          end
        end
      end

      ST_ALIGN: begin
        s_d = s_q | g_q;
        g_d = q_q[0];
        q_d = q_q >> 1;
        k_d = k_q - K_W'(1);
        if (k_q <= K_W'(1)) begin
          state_d = ST_ROUND;
        end
      end

      ST_ROUND: begin
        state_d = ST_OUT;
        flags_d = '0;
        if (round_sum_c[OUT_W]) begin
          res_d             = '1;
          flags_d[FLAG_SAT] = 1'b1;
        end else begin
          res_d = round_sum_c[OUT_W-1:0];
        end
      end

      ST_OUT: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      q_q         <= '0;
      g_q         <= 1'b0;
      s_q         <= 1'b0;
      k_q         <= '0;
      res_q       <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      g_q         <= g_d;
      s_q         <= s_d;
      k_q         <= k_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.int_output = res_q;
  assign bus.out_flags  = flags_q;

endmodule

// File: tb/tb_float_to_int.sv
// Scoreboard bench for float_to_int: RNE and truncating instances driven in lockstep.
module tb_float_to_int;

  logic clk;
  logic rst_n;

  float_to_int_if bus0 ();
  float_to_int_if bus1 ();

  float_to_int #(.ROUND_MODE(0)) u_rne (.clk(clk), .rst_n(rst_n), .bus(bus0));
  float_to_int #(.ROUND_MODE(1)) u_trn (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] stim_q[$];
  logic [21:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact value sig*2^(e-150), integer part plus remainder rounding.
  function automatic logic [10:0] model(input logic [31:0] f, input bit trunc);
    logic [7:0]  e;
    logic [22:0] m;
    logic [31:0] sig, ip, rem, half;
    int          sh;
    e = f[30:23];
    m = f[22:0];
    if (e == 8'hFF && m != 0) return {3'b100, 8'd0};
    if (f[31]) return (e != 0 || m != 0) ? {3'b010, 8'd0} : 11'd0;
    if (e >= 8'd135) return {3'b001, 8'd255};
    if (e < 8'd126) return 11'd0;
    sh   = 150 - int'(e);
    sig  = {9'd0, 1'b1, m};
    ip   = sig >> sh;
    rem  = sig & ((32'd1 << sh) - 32'd1);
    half = 32'd1 << (sh - 1);
    if (!trunc && (rem > half || (rem == half && ip[0]))) ip = ip + 32'd1;
    if (ip > 32'd255) return {3'b001, 8'd255};
    return {3'b000, ip[7:0]};
  endfunction

  function automatic logic [31:0] enc(input int n);
    int p;
    logic [31:0] mag;
    if (n == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 8; i++) if (n[i]) p = i;
    mag = 32'(n) << (23 - p);
    return {1'b0, 8'(127 + p), mag[22:0]};
  endfunction

  task automatic set_in(input logic v, input logic [31:0] d);
    bus0.in_valid = v; bus0.float_input = d;
    bus1.in_valid = v; bus1.float_input = d;
  endtask

  task automatic set_ordy(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  // Single accept from IDLE with out_ready high; measures edges to out_valid.
  task automatic lat_check(input logic [31:0] op, input int lat,
                           input logic [10:0] e_rne, input logic [10:0] e_trn);
    int n;
    set_ordy(1'b1);
    @(negedge clk);
    check("idle_ready", 32'(bus0.in_ready), 32'd1);
    set_in(1'b1, op);
    @(negedge clk);
    set_in(1'b0, 32'd0);
    n = 1;
    while (!bus0.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("rne_result", 32'({bus0.out_flags, bus0.int_output}), 32'(e_rne));
    check("trn_result", 32'({bus1.out_flags, bus1.int_output}), 32'(e_trn));
    @(negedge clk);
    check("valid_drop", 32'(bus0.out_valid), 32'd0);
  endtask

  task automatic run_stream(input bit rnd);
    int          budget;
    bit          drop;
    logic [31:0] op;
    logic [21:0] e;
    budget = 40000;
    drop   = 1'b0;
    set_in(1'b0, 32'd0);
    while ((stim_q.size() > 0 || bus0.in_valid || sb_q.size() > 0) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (drop) begin
        set_in(1'b0, 32'd0);
        drop = 1'b0;
      end
      if (!bus0.in_valid && stim_q.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
        op = stim_q.pop_front();
        set_in(1'b1, op);
      end
      if (bus0.in_valid && bus0.in_ready) begin
        sb_q.push_back({model(bus0.float_input, 1'b1), model(bus0.float_input, 1'b0)});
        drop = 1'b1;
      end
      set_ordy(!rnd || $urandom_range(0, 3) != 0);
      if (bus0.out_valid && bus0.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_rne", 32'({bus0.out_flags, bus0.int_output}), 32'(e[10:0]));
          check("sb_trn", 32'({bus1.out_flags, bus1.int_output}), 32'(e[21:11]));
          check("sb_valid_lockstep", 32'(bus1.out_valid), 32'd1);
        end
      end
    end
    check("stream_budget", 32'(budget > 0), 32'd1);
    check("stream_sb_empty", 32'(sb_q.size()), 32'd0);
    set_ordy(1'b1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    set_in(1'b0, 32'd0);
    set_ordy(1'b0);
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus0.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_int_output", 32'(bus0.int_output), 32'd0);
    check("rst_flags", 32'(bus0.out_flags), 32'd0);
    rst_n = 1'b1;

    lat_check(32'h43480000, 2,  {3'b000, 8'd200}, {3'b000, 8'd200});
    lat_check(32'h3F000000, 10, {3'b000, 8'd0},   {3'b000, 8'd0});
    lat_check(32'h3FC00000, 9,  {3'b000, 8'd2},   {3'b000, 8'd1});
    lat_check(32'h40200000, 8,  {3'b000, 8'd2},   {3'b000, 8'd2});
    lat_check(32'h3F400000, 10, {3'b000, 8'd1},   {3'b000, 8'd0});
    lat_check(32'h437F8000, 2,  {3'b001, 8'd255}, {3'b000, 8'd255});
    lat_check(32'h7F800000, 1,  {3'b001, 8'd255}, {3'b001, 8'd255});
    lat_check(32'hBF800000, 1,  {3'b010, 8'd0},   {3'b010, 8'd0});
    lat_check(32'h7FC00000, 1,  {3'b100, 8'd0},   {3'b100, 8'd0});
    lat_check(32'h80000000, 1,  {3'b000, 8'd0},   {3'b000, 8'd0});
    lat_check(32'h00000001, 1,  {3'b000, 8'd0},   {3'b000, 8'd0});
    lat_check(32'h3E800000, 1,  {3'b000, 8'd0},   {3'b000, 8'd0});

    // Backpressure: result held, new input ignored while OUT is stalled.
    set_ordy(1'b0);
    @(negedge clk);
    set_in(1'b1, 32'h43480000);
    @(negedge clk);
    set_in(1'b1, 32'h3F800000);
    n = 0;
    while (!bus0.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_reached_out", 32'(bus0.out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_value", 32'(bus0.int_output), 32'd200);
      check("bp_hold_valid", 32'(bus0.out_valid), 32'd1);
      check("bp_in_ready_low", 32'(bus0.in_ready), 32'd0);
    end
    set_in(1'b0, 32'd0);
    set_ordy(1'b1);
    @(negedge clk);
    check("bp_release_valid", 32'(bus0.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus0.in_ready), 32'd1);

    // Asynchronous reset in the middle of alignment.
    @(negedge clk);
    set_in(1'b1, 32'h3F000000);
    @(negedge clk);
    set_in(1'b0, 32'd0);
    repeat (3) @(negedge clk);
    check("mid_align_busy", 32'(bus0.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(bus0.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    lat_check(32'h43480000, 2, {3'b000, 8'd200}, {3'b000, 8'd200});

    // Exhaustive integer round trip, then edge values and random operands.
    for (int i = 0; i < 256; i++) stim_q.push_back(enc(i));
    run_stream(1'b0);
    for (int i = 0; i < 256; i++) stim_q.push_back(enc(i));
    stim_q.push_back(32'h437F8000);
    stim_q.push_back(32'h437F0000);
    stim_q.push_back(32'h3FC00000);
    stim_q.push_back(32'h7FC00001);
    stim_q.push_back(32'hFF800000);
    stim_q.push_back(32'h807FFFFF);
    for (int i = 0; i < 200; i++)
      stim_q.push_back({1'($urandom_range(0, 7) == 0), 8'($urandom_range(120, 137)), 23'($urandom)});
    run_stream(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
